seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display path (9-bit value into the
//  decimal split/encode/scan chain) between three requesters, e.g. score, timer
//  and status. Round-robin arbitration uses a req/gnt handshake.
//  A minimum display time (HOLD) stops flicker. A time slice (SLICE) stops one
//  source from starving the others. Sits between game logic and the display driver.
// PARAMETERS
//  CNT_W        16       width of hold/slice counter
//  HOLD_CYCLES  16'd50000 min cycles a granted value stays on display (>=1)
//  SLICE_CYCLES 16'd60000 max cycles an owner keeps the grant while others wait (>=HOLD_CYCLES)
//  IDLE_VAL     9'd0     value driven on disp_val when no source owns the display
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  req        in   3  request per source, level; held while source wants display
//  val0       in   9  value of source 0 (0..511)
//  val1       in   9  value of source 1
//  val2       in   9  value of source 2
//  gnt        out  3  one-hot grant, registered; 000 when no owner
//  disp_val   out  9  value to display driver, registered
//  disp_valid out  1  1 while a grant or linger is in progress
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, gnt=000, disp_val=IDLE_VAL, disp_valid=0,
//    hold_cnt=0, last_owner=2 (source 0 wins first). A mid-operation reset
//    aborts any grant at once.
//  - States: IDLE, GRANT(owner o), LINGER(owner o). All outputs change only on clk edges.
//  - Arbitration: search from last_owner+1 mod 3 upward for the first set req bit.
//    The winner w sets gnt=onehot(w), last_owner=w, hold_cnt=0 and disp_val<=val_w
//    on the same edge. Latency from req to gnt is 1 cycle.
//  - GRANT: every cycle disp_val<=val_o (tracks live value, 1-cycle delay).
//    hold_cnt increments and saturates at SLICE_CYCLES-1. Checks, in priority order:
//    a) req[o]=0, hold_cnt>=HOLD_CYCLES-1: re-arbitrate this edge. Go to GRANT(new)
//       if any req is set, else IDLE (gnt=000, disp_val=IDLE_VAL, disp_valid=0).
//    b) req[o]=0, hold_cnt<HOLD_CYCLES-1: go to LINGER. gnt=000, disp_val frozen,
//       disp_valid=1.
//    c) req[o]=1, another req set, hold_cnt>=SLICE_CYCLES-1: rotate to the next
//       requester by round-robin.
//    d) Otherwise stay.
//  - LINGER: hold_cnt keeps counting. If req[o] reasserts, return to GRANT(o) without
//    clearing hold_cnt. When hold_cnt reaches HOLD_CYCLES-1, arbitrate as in a).
//  - A dropped owner can win again only by round-robin order. Simultaneous
//    requests are resolved by the round-robin pointer alone.
//  - gnt is always one-hot or zero. disp_valid=1 iff state != IDLE.
// CONFIGURATION
//  PRIORITY_EN defined: req[0] is urgent. In GRANT(o!=0) or LINGER(o!=0) with req[0]=1,
//    the next edge grants source 0 regardless of HOLD/SLICE (hold_cnt=0, last_owner=0).
//    Source 0 itself is never sliced while req[0]=1 (rule c disabled for o=0).
//  PRIORITY_EN undefined: pure round-robin; source 0 has no special rights.
// TESTING (HOLD_CYCLES=4, SLICE_CYCLES=8, val0=123, val1=45, val2=7)
//  1. Reset pulse, req=000 -> gnt=000, disp_val=0, disp_valid=0 held for 20 cycles.
//  2. req=011 at cycle 0 -> gnt=001, disp_val=123 at cycle 1. Drop req0 at cycle 6
//     -> gnt=010, disp_val=45 at cycle 7.
//  3. req0 one-cycle pulse -> gnt=001 for 1 cycle, then disp_val=123 and disp_valid=1
//     until 4 cycles after grant, then IDLE with disp_val=0.
//  4. req=101 held -> gnt alternates 001/100 every 8 cycles. Change val0 to 200 while
//     granted -> disp_val=200 one cycle later.
//  5. Owner 1 at hold_cnt=1, assert req0 -> with PRIORITY_EN gnt=001 next edge.
//     Without it, gnt stays 010 until the slice expires (hold_cnt=7).
//  6. Assert rst_n=0 between clk edges mid-GRANT -> gnt=000, disp_val=0,
//     disp_valid=0 before the next edge.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin owner selection for the shared 4-digit seven-segment display path.
// Three requesters compete for one 9-bit display value.
// HOLD_CYCLES sets the minimum time a granted value stays on the display, so the
// display does not flicker.
// SLICE_CYCLES sets the longest time an owner keeps the grant while others wait,
// so no source starves the others.
// Optional feature: define PRIORITY_EN to make source 0 urgent. Source 0 then
// pre-empts any other owner and is never time-sliced while it requests.
module seg_display_arbiter #(
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] HOLD_CYCLES  = CNT_W'(50000),
    parameter logic [CNT_W-1:0] SLICE_CYCLES = CNT_W'(60000),
    parameter logic [8:0]       IDLE_VAL     = 9'd0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    input  logic [8:0] val0_i,
    input  logic [8:0] val1_i,
    input  logic [8:0] val2_i,
    output logic [2:0] gnt_o,
    output logic [8:0] disp_val_o,
    output logic       disp_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LINGER} state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST  = HOLD_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] SLICE_LAST = SLICE_CYCLES - 1'b1;

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [8:0]       disp_val_q, disp_val_d;
    logic             disp_valid_q, disp_valid_d;

    logic [1:0]       c0, c1, c2, win;
    logic             any_req, others_req, prio_hit, slice_en, arb_go;
    logic [CNT_W-1:0] hold_inc;

    function automatic logic [8:0] sel_val(input logic [1:0] i, input logic [8:0] a,
                                           input logic [8:0] b, input logic [8:0] c);
        case (i)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // Round-robin search: the first requester after the last owner, modulo 3
    always_comb begin
        c0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (req_i[c0])      win = c0;
        else if (req_i[c1]) win = c1;
        else                win = c2;
    end

    assign any_req    = |req_i;
    assign others_req = |(req_i & ~onehot(owner_q));
    // The counter saturates at the slice limit, so it cannot wrap during a long grant
    assign hold_inc   = (hold_q < SLICE_LAST) ? hold_q + 1'b1 : hold_q;

`ifdef PRIORITY_EN
    // Source 0 pre-empts any other owner. It also cannot be sliced away while it still requests.
    assign prio_hit = req_i[0] && (owner_q != 2'd0);
    assign slice_en = (owner_q != 2'd0) || !req_i[0];
`else
    assign prio_hit = 1'b0;
    assign slice_en = 1'b1;
`endif

    // Next-state decision for owner, hold timer and display outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        disp_val_d = disp_val_q;
        arb_go     = 1'b0;

        case (state_q)
            S_IDLE: arb_go = 1'b1;
            S_GRANT: begin
                hold_d     = hold_inc;
                disp_val_d = sel_val(owner_q, val0_i, val1_i, val2_i);
                if (prio_hit) begin
                    state_d    = S_GRANT;
                    owner_d    = 2'd0;
                    last_d     = 2'd0;
                    hold_d     = '0;
                    gnt_d      = 3'b001;
                    disp_val_d = val0_i;
                end else if (!req_i[owner_q]) begin
                    if (hold_q >= HOLD_LAST) begin
                        arb_go = 1'b1;
                    end else begin
                        // The owner left early. Keep its value on the display for the rest of the hold time.
                        state_d    = S_LINGER;
                        gnt_d      = 3'b000;
                        disp_val_d = disp_val_q;
                    end
                end else if (slice_en && others_req && (hold_q >= SLICE_LAST)) begin
                    arb_go = 1'b1;
                end
            end
            S_LINGER: begin
                hold_d = hold_inc;
                if (prio_hit) begin
                    state_d    = S_GRANT;
                    owner_d    = 2'd0;
                    last_d     = 2'd0;
                    hold_d     = '0;
                    gnt_d      = 3'b001;
                    disp_val_d = val0_i;
                end else if (req_i[owner_q]) begin
                    // The owner came back. It keeps its hold time already elapsed.
                    state_d    = S_GRANT;
                    gnt_d      = onehot(owner_q);
                    disp_val_d = sel_val(owner_q, val0_i, val1_i, val2_i);
                end else if (hold_q >= HOLD_LAST) begin
                    arb_go = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        if (arb_go) begin
            if (any_req) begin
                state_d    = S_GRANT;
                owner_d    = win;
                last_d     = win;
                hold_d     = '0;
                gnt_d      = onehot(win);
                disp_val_d = sel_val(win, val0_i, val1_i, val2_i);
            end else begin
                state_d    = S_IDLE;
                hold_d     = '0;
                gnt_d      = 3'b000;
                disp_val_d = IDLE_VAL;
            end
        end

        disp_valid_d = (state_d != S_IDLE);
    end

    // Register the state and all outputs. Reset clears any grant at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= 2'd0;
            last_q       <= 2'd2;
            hold_q       <= '0;
            gnt_q        <= 3'b000;
            disp_val_q   <= IDLE_VAL;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            gnt_q        <= gnt_d;
            disp_val_q   <= disp_val_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign disp_val_o   = disp_val_q;
    assign disp_valid_o = disp_valid_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter
// Directed scoreboard bench for seg_display_arbiter with HOLD=4, SLICE=8.
// The driver pushes the output expected after the coming rising edge.
// A separate monitor pops and compares each entry.
// Expectations follow PRIORITY_EN when the macro is defined.
module tb_seg_display_arbiter;

    typedef struct {
        logic [2:0] gnt;
        logic [8:0] val;
        logic       vld;
        string      tag;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] req_i = 3'b000;
    logic [8:0] val0_i = 9'd123;
    logic [8:0] val1_i = 9'd45;
    logic [8:0] val2_i = 9'd7;
    logic [2:0] gnt_o;
    logic [8:0] disp_val_o;
    logic       disp_valid_o;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   test_id = 0;
    int   step_no = 0;

    seg_display_arbiter #(
        .CNT_W       (16),
        .HOLD_CYCLES (16'd4),
        .SLICE_CYCLES(16'd8),
        .IDLE_VAL    (9'd0)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .val0_i      (val0_i),
        .val1_i      (val1_i),
        .val2_i      (val2_i),
        .gnt_o       (gnt_o),
        .disp_val_o  (disp_val_o),
        .disp_valid_o(disp_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push_exp(input logic [2:0] eg, input logic [8:0] ev, input logic evld);
        exp_t e;
        e.gnt = eg;
        e.val = ev;
        e.vld = evld;
        e.tag = $sformatf("t%0d.s%0d", test_id, step_no);
        step_no++;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge. Queue the outputs expected after the next rising edge.
    task automatic step(input logic [2:0] r, input logic [8:0] v0,
                        input logic [2:0] eg, input logic [8:0] ev, input logic evld);
        @(negedge clk_i);
        req_i  = r;
        val0_i = v0;
        push_exp(eg, ev, evld);
    endtask

    // Monitor: compare the outputs after each rising edge, and also just after an asynchronous reset
    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (gnt_o === e.gnt && disp_val_o === e.val && disp_valid_o === e.vld)
                    passes++;
                else
                    $display("FAIL %s: got gnt=%b val=%0d vld=%b, want gnt=%b val=%0d vld=%b",
                             e.tag, gnt_o, disp_val_o, disp_valid_o, e.gnt, e.val, e.vld);
            end
        end
    end

    initial begin
        // 1: reset state, then idle for 20 cycles
        test_id = 1; step_no = 0;
        repeat (2) @(negedge clk_i);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);

        // 2: source 0 wins first. Dropping req0 hands the display to source 1.
        test_id = 2; step_no = 0;
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
        repeat (5) step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
        step(3'b010, 9'd123, 3'b010, 9'd45, 1'b1);
        repeat (3) step(3'b000, 9'd123, 3'b000, 9'd45, 1'b1);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);

        // 3: a one-cycle pulse on req0 leaves the value shown for the hold time
        test_id = 3; step_no = 0;
        step(3'b001, 9'd123, 3'b001, 9'd123, 1'b1);
        repeat (3) step(3'b000, 9'd123, 3'b000, 9'd123, 1'b1);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);

        // 4: sources 0 and 2 both request. Source 0 changes its live value while granted.
        test_id = 4; step_no = 0;
        step(3'b101, 9'd123, 3'b100, 9'd7, 1'b1);
`ifdef PRIORITY_EN
        repeat (3) step(3'b101, 9'd123, 3'b001, 9'd123, 1'b1);
        step(3'b101, 9'd200, 3'b001, 9'd200, 1'b1);
        repeat (8) step(3'b101, 9'd200, 3'b001, 9'd200, 1'b1);
        step(3'b000, 9'd200, 3'b000, 9'd0, 1'b0);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);
`else
        repeat (7) step(3'b101, 9'd123, 3'b100, 9'd7, 1'b1);
        repeat (3) step(3'b101, 9'd123, 3'b001, 9'd123, 1'b1);
        repeat (5) step(3'b101, 9'd200, 3'b001, 9'd200, 1'b1);
        step(3'b101, 9'd123, 3'b100, 9'd7, 1'b1);
        repeat (3) step(3'b000, 9'd123, 3'b000, 9'd7, 1'b1);
        step(3'b000, 9'd123, 3'b000, 9'd0, 1'b0);
`endif

        // 5: source 0 requests while source 1 owns the display at hold_cnt=1
        test_id = 5; step_no = 0;
        step(3'b010, 9'd123, 3'b010, 9'd45, 1'b1);
        step(3'b010, 9'd123, 3'b010, 9'd45, 1'b1);
`ifdef PRIORITY_EN
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
`else
        repeat (6) step(3'b011, 9'd123, 3'b010, 9'd45, 1'b1);
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
`endif

        // 6: an asynchronous reset between edges clears the grant before the next edge
        test_id = 6; step_no = 0;
        @(posedge clk_i);
        #3;
        push_exp(3'b000, 9'd0, 1'b0);
        rst_ni = 1'b0;
        step(3'b011, 9'd123, 3'b000, 9'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        req_i  = 3'b000;
        step(3'b011, 9'd123, 3'b001, 9'd123, 1'b1);
        step(3'b000, 9'd123, 3'b000, 9'd123, 1'b1);

        @(posedge clk_i);
        #2;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
